// File: rtl/wash_cycle_ctrl.sv
// Washing-machine program sequencer: FILL/HEAT/WASH/DRAIN/RINSE/SPIN timed by 1 Hz ticks.
// Build with WASH_EXTRA_RINSE_EN defined for a second rinse pass.
module wash_cycle_ctrl #(
  parameter int FILL_T      = 8,
  parameter int HEAT_HOT_T  = 8,
  parameter int HEAT_WARM_T = 4,
  parameter int WASH_T      = 10,
  parameter int DRAIN_T     = 4,
  parameter int RINSE_T     = 6,
  parameter int SPIN_T      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [2:0] temp_sel,
  output logic [2:0] phase,
  output logic [7:0] phase_left,
  output logic       temp_en,
  output logic       valve_in,
  output logic       valve_out,
  output logic       heater,
  output logic [1:0] motor
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_HEAT  = 3'd2;
  localparam logic [2:0] S_WASH  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_RINSE = 3'd5;
  localparam logic [2:0] S_SPIN  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

`ifdef WASH_EXTRA_RINSE_EN
  localparam logic [1:0] R_MAX = 2'd2;
`else
  localparam logic [1:0] R_MAX = 2'd1;
`endif

  logic [2:0] r_phase;
  logic [7:0] r_left;
  logic [2:0] r_temp_q;
  logic [1:0] r_rinse_cnt;
  logic       r_abort_flag;

  logic       w_idle;
  logic [2:0] w_nxt_phase;
  logic [7:0] w_nxt_left;
  logic [2:0] w_temp_dec;

  assign w_idle = (r_phase == S_IDLE) || (r_phase == S_DONE);

  always_comb begin
    w_temp_dec = 3'd2;
    if (temp_sel == 3'd1 || temp_sel == 3'd2 || temp_sel == 3'd4) w_temp_dec = temp_sel;
  end

  // Successor phase and its load value, used when the current phase's last tick arrives.
  always_comb begin
    w_nxt_phase = r_phase;
    w_nxt_left  = 8'd0;
    case (r_phase)
      S_FILL: begin
        if (r_temp_q == 3'd4) begin
          w_nxt_phase = S_WASH;
          w_nxt_left  = 8'(WASH_T);
        end else begin
          w_nxt_phase = S_HEAT;
          w_nxt_left  = (r_temp_q == 3'd1) ? 8'(HEAT_HOT_T) : 8'(HEAT_WARM_T);
        end
      end
      S_HEAT: begin
        w_nxt_phase = S_WASH;
        w_nxt_left  = 8'(WASH_T);
      end
      S_WASH, S_RINSE: begin
        w_nxt_phase = S_DRAIN;
        w_nxt_left  = 8'(DRAIN_T);
      end
      S_DRAIN: begin
        if (r_abort_flag) begin
          w_nxt_phase = S_IDLE;
        end else if (r_rinse_cnt < R_MAX) begin
          w_nxt_phase = S_RINSE;
          w_nxt_left  = 8'(RINSE_T);
        end else begin
          w_nxt_phase = S_SPIN;
          w_nxt_left  = 8'(SPIN_T);
        end
      end
      S_SPIN: w_nxt_phase = S_DONE;
      default: w_nxt_phase = r_phase;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase      <= S_IDLE;
      r_left       <= 8'd0;
      r_temp_q     <= 3'd0;
      r_rinse_cnt  <= 2'd0;
      r_abort_flag <= 1'b0;
    end else if (abort && !w_idle) begin
      // Abort outranks pause and tick; DRAIN keeps its running timer.
      if (r_phase == S_SPIN) begin
        r_phase      <= S_IDLE;
        r_left       <= 8'd0;
        r_abort_flag <= 1'b0;
      end else begin
        if (r_phase != S_DRAIN) begin
          r_phase <= S_DRAIN;
          r_left  <= 8'(DRAIN_T);
        end
        r_abort_flag <= 1'b1;
      end
    end else if (w_idle) begin
      if (start && !pause) begin
        r_phase      <= S_FILL;
        r_left       <= 8'(FILL_T);
        r_temp_q     <= w_temp_dec;
        r_rinse_cnt  <= 2'd0;
        r_abort_flag <= 1'b0;
      end
    end else if (tick && !pause) begin
      if (r_left == 8'd1) begin
        r_phase <= w_nxt_phase;
        r_left  <= w_nxt_left;
        if (r_phase == S_RINSE) r_rinse_cnt <= r_rinse_cnt + 2'd1;
        if (r_phase == S_DRAIN) r_abort_flag <= 1'b0;
      end else begin
        r_left <= r_left - 8'd1;
      end
    end
  end

  assign phase      = r_phase;
  assign phase_left = r_left;
  assign temp_en    = w_idle;
  assign valve_in   = !pause && (r_phase == S_FILL || r_phase == S_RINSE);
  assign heater     = !pause && (r_phase == S_HEAT);
  assign valve_out  = !pause && (r_phase == S_DRAIN || r_phase == S_SPIN);
  assign motor      = pause ? 2'b00 :
                      (r_phase == S_WASH || r_phase == S_RINSE) ? 2'b01 :
                      (r_phase == S_SPIN) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: directed program scenarios plus random traffic vs a plan-queue model.
module tb_wash_cycle_ctrl;
  localparam int FILL_T = 8, HOT_T = 8, WARM_T = 4, WASH_T = 10;
  localparam int DRAIN_T = 4, RINSE_T = 6, SPIN_T = 6;
`ifdef WASH_EXTRA_RINSE_EN
  localparam int R_MAX = 2;
`else
  localparam int R_MAX = 1;
`endif

  logic clk = 0, reset = 0, tick = 0, start = 0, pause = 0, abort = 0;
  logic [2:0] temp_sel = 3'd1;
  logic [2:0] phase;
  logic [7:0] phase_left;
  logic temp_en, valve_in, valve_out, heater;
  logic [1:0] motor;

  wash_cycle_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause), .abort(abort),
    .temp_sel(temp_sel), .phase(phase), .phase_left(phase_left), .temp_en(temp_en),
    .valve_in(valve_in), .valve_out(valve_out), .heater(heater), .motor(motor)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int m_ph = 0, m_left = 0;
  int q_ph[$], q_d[$];
  int rec[$];
  bit rec_on = 0;
  int last_ph = 0, heat_ticks = 0, heat_cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a program is a queue of (phase, duration) entries, popped as each phase expires.
  task automatic m_next();
    if (q_ph.size() == 0) begin
      m_ph = 0; m_left = 0;
    end else begin
      m_ph = q_ph.pop_front(); m_left = q_d.pop_front();
    end
  endtask

  task automatic m_plan(input int t);
    q_ph.delete(); q_d.delete();
    q_ph.push_back(1); q_d.push_back(FILL_T);
    if (t != 4) begin q_ph.push_back(2); q_d.push_back(t == 1 ? HOT_T : WARM_T); end
    q_ph.push_back(3); q_d.push_back(WASH_T);
    for (int r = 0; r < R_MAX; r++) begin
      q_ph.push_back(4); q_d.push_back(DRAIN_T);
      q_ph.push_back(5); q_d.push_back(RINSE_T);
    end
    q_ph.push_back(4); q_d.push_back(DRAIN_T);
    q_ph.push_back(6); q_d.push_back(SPIN_T);
    q_ph.push_back(7); q_d.push_back(0);
  endtask

  task automatic m_step();
    int t;
    if (reset) begin
      m_ph = 0; m_left = 0; q_ph.delete(); q_d.delete();
    end else if (abort && m_ph != 0 && m_ph != 7) begin
      q_ph.delete(); q_d.delete();
      if (m_ph == 6) begin
        m_ph = 0; m_left = 0;
      end else begin
        q_ph.push_back(0); q_d.push_back(0);
        if (m_ph != 4) begin m_ph = 4; m_left = DRAIN_T; end
      end
    end else if (m_ph == 0 || m_ph == 7) begin
      if (start && !pause) begin
        t = int'(temp_sel);
        if (t != 1 && t != 2 && t != 4) t = 2;
        m_plan(t);
        m_next();
      end
    end else if (tick && !pause) begin
      if (m_left == 1) m_next();
      else m_left--;
    end
  endtask

  task automatic check_outputs();
    chk("phase", int'(phase), m_ph);
    chk("phase_left", int'(phase_left), m_left);
    chk("temp_en", int'(temp_en), int'(m_ph == 0 || m_ph == 7));
    chk("valve_in", int'(valve_in), int'(!pause && (m_ph == 1 || m_ph == 5)));
    chk("heater", int'(heater), int'(!pause && m_ph == 2));
    chk("valve_out", int'(valve_out), int'(!pause && (m_ph == 4 || m_ph == 6)));
    chk("motor", int'(motor), pause ? 0 : (m_ph == 3 || m_ph == 5) ? 1 : (m_ph == 6) ? 2 : 0);
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (rec_on && int'(phase) != last_ph) rec.push_back(int'(phase));
    last_ph = int'(phase);
    if (heater) heat_cyc++;
    if (heater && tick) heat_ticks++;
    @(posedge clk);
    m_step();
    #1;
    start = 0; abort = 0; reset = 0; tick = 0;
  endtask

  task automatic run_ticks(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      repeat (per - 1) step();
      tick = 1;
      step();
    end
  endtask

  task automatic wait_for(input int ph, input int lf);
    int b;
    b = 0;
    while (!(m_ph == ph && m_left == lf) && b < 400) begin
      tick = (b % 4 == 3);
      step();
      b++;
    end
    if (b >= 400) chk("wait_budget", b, 0);
  endtask

  initial begin
    int exp_seq[$];
    // Reset must win over simultaneous start/abort/tick.
    reset = 1; start = 1; abort = 1; tick = 1;
    @(posedge clk); #1;
    reset = 0; start = 0; abort = 0; tick = 0;
    chk("rst_phase", int'(phase), 0);
    chk("rst_left", int'(phase_left), 0);
    chk("rst_temp_en", int'(temp_en), 1);
    chk("rst_act", int'({valve_in, valve_out, heater, motor}), 0);

    // Full hot program.
    exp_seq = {1, 2, 3};
    for (int r = 0; r < R_MAX; r++) begin exp_seq.push_back(4); exp_seq.push_back(5); end
    exp_seq.push_back(4); exp_seq.push_back(6); exp_seq.push_back(7);
    temp_sel = 3'd1; start = 1; rec_on = 1; last_ph = 0; heat_ticks = 0;
    step();
    run_ticks(60, 4);
    rec_on = 0;
    chk("seq_len", rec.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < rec.size(); i++) chk("seq_phase", rec[i], exp_seq[i]);
    chk("hot_heat_ticks", heat_ticks, HOT_T);
    chk("done_phase", int'(phase), 7);
    chk("done_temp_en", int'(temp_en), 1);

    // Cold: FILL goes straight to WASH, no heat.
    temp_sel = 3'd4; start = 1; heat_cyc = 0;
    step();
    run_ticks(FILL_T, 4);
    chk("cold_after_fill", int'(phase), 3);
    run_ticks(60, 4);
    chk("cold_heat_cycles", heat_cyc, 0);

    // Invalid selection behaves as warm.
    temp_sel = 3'b011; start = 1;
    step();
    run_ticks(FILL_T, 4);
    chk("warm_heat_entry", int'(phase), 2);
    run_ticks(WARM_T - 1, 4);
    chk("warm_heat_hold", int'(phase), 2);
    run_ticks(1, 4);
    chk("warm_heat_exit", int'(phase), 3);
    run_ticks(60, 4);

    // Pause mid-WASH drops ticks.
    temp_sel = 3'd4; start = 1;
    step();
    wait_for(3, 6);
    pause = 1;
    run_ticks(5, 4);
    chk("pause_left", int'(phase_left), 6);
    chk("pause_motor", int'(motor), 0);
    chk("pause_phase", int'(phase), 3);
    pause = 0;
    run_ticks(5, 4);
    chk("resume_wash", int'(phase), 3);
    run_ticks(1, 4);
    chk("resume_drain", int'(phase), 4);
    run_ticks(60, 4);

    // Abort in HEAT, then in SPIN.
    temp_sel = 3'd1; start = 1;
    step();
    wait_for(2, 5);
    abort = 1;
    step();
    chk("abort_heat_phase", int'(phase), 4);
    chk("abort_heat_vout", int'(valve_out), 1);
    run_ticks(DRAIN_T - 1, 4);
    chk("abort_drain_hold", int'(phase), 4);
    run_ticks(1, 4);
    chk("abort_to_idle", int'(phase), 0);
    temp_sel = 3'd2; start = 1;
    step();
    wait_for(6, 3);
    abort = 1;
    step();
    chk("abort_spin", int'(phase), 0);

    // Reset with a coincident tick mid-RINSE.
    temp_sel = 3'd2; start = 1;
    step();
    wait_for(5, 3);
    reset = 1; tick = 1;
    step();
    chk("rst_rinse_phase", int'(phase), 0);
    chk("rst_rinse_act", int'({valve_in, valve_out, heater, motor}), 0);

    // Random traffic.
    for (int c = 0; c < 15000; c++) begin
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) pause = !pause;
      start = ($urandom_range(0, 29) == 0);
      abort = !start && ($urandom_range(0, 149) == 0);
      reset = ($urandom_range(0, 2999) == 0);
      temp_sel = 3'($urandom);
      step();
    end
    pause = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
